// File: rtl/ndn_pkt_pkg.sv
// ndn_pkt_pkg
// Shared constants and types for the NDN SPI receive path.
//   - Packet lengths: interest = metadata + 64-bit prefix, data = interest + 256-bit payload.
//   - TYPE_BIT selects interest (1) or data (0) inside the metadata byte.
//   - Receive / transmit state encodings for spi_rx_framer.
package ndn_pkt_pkg;

  localparam logic [5:0] INTEREST_BYTES = 6'd9;
  localparam logic [5:0] DATA_BYTES     = 6'd41;
  localparam int         TYPE_BIT       = 6;

  localparam logic [7:0] META_INTEREST  = 8'h70;
  localparam logic [7:0] META_DATA      = 8'h30;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_BODY = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_START  = 2'd1,
    TX_STREAM = 2'd2
  } tx_state_e;

  // Total packet length implied by a metadata byte.
  function automatic logic [5:0] pkt_len(input logic [7:0] meta);
    if (meta[TYPE_BIT]) begin
      return INTEREST_BYTES;
    end else begin
      return DATA_BYTES;
    end
  endfunction

endpackage

// File: rtl/spi_rx_framer_if.sv
// spi_rx_framer_if
// Bundles the SPI slave pins and the FIB-facing outputs of spi_rx_framer.
//   master : drives spi_sclk / spi_mosi / spi_cs_n, observes the FIB side.
//   slave  : the framer; receives SPI pins, drives RX_valid, data_SPI_to_FIB,
//            busy, packet_dropped and drop_count.
interface spi_rx_framer_if;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       RX_valid;
  logic [7:0] data_SPI_to_FIB;
  logic       busy;
  logic       packet_dropped;
  logic [7:0] drop_count;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
    input  RX_valid, data_SPI_to_FIB, busy, packet_dropped, drop_count
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
    output RX_valid, data_SPI_to_FIB, busy, packet_dropped, drop_count
  );
endinterface

// File: rtl/spi_byte_deserializer.sv
// spi_byte_deserializer
// Brings the asynchronous SPI pins into the clk domain and assembles bytes.
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   sclk_i, mosi_i, cs_n_i   raw SPI pins (mode 0, MSB first)
//   byte_o            last assembled byte
//   byte_strobe_o     one-cycle pulse when byte_o is new
//   cs_rise_o         one-cycle pulse on synchronised chip-select deassertion
//   cs_n_sync_o       synchronised chip select level
module spi_byte_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic [7:0] byte_o,
  output logic       byte_strobe_o,
  output logic       cs_rise_o,
  output logic       cs_n_sync_o
);

  logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic       cs_meta_q, cs_sync_q, cs_prev_q;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q;
  logic       strobe_q, cs_rise_q;
  logic       sclk_rise_s, cs_rise_s, shift_en_s;

  assign sclk_rise_s = sclk_sync_q & ~sclk_prev_q;
  assign cs_rise_s   = cs_sync_q & ~cs_prev_q;
  assign shift_en_s  = ~cs_sync_q & sclk_rise_s;

  // Next shift/bit-count state; a chip-select release always restarts byte alignment.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (cs_rise_s) begin
      bit_cnt_d = 3'd0;
    end else if (shift_en_s) begin
      shift_d   = {shift_q[5:0], mosi_sync_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Two-flop synchronisers plus edge-history flops; idle bus is sclk=0, cs_n=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      cs_meta_q   <= cs_n_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
    end
  end

  // Shift register, bit counter and registered byte/strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= 7'd0;
      bit_cnt_q <= 3'd0;
      byte_q    <= 8'd0;
      strobe_q  <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cs_rise_q <= cs_rise_s;
      // The eighth bit completes the byte directly from the incoming sample.
      if (!cs_rise_s && shift_en_s && (bit_cnt_q == 3'd7)) begin
        byte_q   <= {shift_q, mosi_sync_q};
        strobe_q <= 1'b1;
      end else begin
        strobe_q <= 1'b0;
      end
    end
  end

  assign byte_o        = byte_q;
  assign byte_strobe_o = strobe_q;
  assign cs_rise_o     = cs_rise_q;
  assign cs_n_sync_o   = cs_sync_q;

endmodule

// File: rtl/spi_rx_framer.sv
// spi_rx_framer
// Receives one NDN packet over SPI, buffers it, then replays it to the FIB as
// an RX_valid pulse followed by one byte per clock.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   spi_rx_framer_if.slave:
//           spi_sclk/spi_mosi/spi_cs_n  SPI slave pins (sclk <= clk/4)
//           RX_valid        one-cycle packet-start pulse
//           data_SPI_to_FIB packet byte stream
//           busy            high from the RX_valid cycle through the last byte
//           packet_dropped  one-cycle pulse when a partial packet is discarded
//           drop_count      saturating drop counter
// Build option: define SPI_RX_DROP_COUNT_EN to implement drop_count; otherwise
// it reads as zero and no counter flops exist.
module spi_rx_framer
  import ndn_pkt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  spi_rx_framer_if.slave  bus
);

  logic [7:0] byte_s;
  logic       byte_strobe_s, cs_rise_s, cs_n_sync_s;

  spi_byte_deserializer u_deser (
    .clk           (clk),
    .rst           (rst),
    .sclk_i        (bus.spi_sclk),
    .mosi_i        (bus.spi_mosi),
    .cs_n_i        (bus.spi_cs_n),
    .byte_o        (byte_s),
    .byte_strobe_o (byte_strobe_s),
    .cs_rise_o     (cs_rise_s),
    .cs_n_sync_o   (cs_n_sync_s)
  );

  rx_state_e  rx_state_q;
  logic [5:0] wr_ptr_q, expected_len_q;
  logic       done_q;           // packet complete in this frame; wait for cs_n release
  logic       pkt_ready_q, packet_dropped_q;

  tx_state_e  tx_state_q;
  logic [5:0] rd_ptr_q, tx_len_q;
  logic       rx_valid_q, busy_q;
  logic [7:0] data_q;

  logic [7:0] pkt_buf_q [0:DATA_BYTES-1];
  logic       wr_en_s;
  logic [5:0] wr_addr_s;

  // Buffer write port: byte 0 starts a packet from idle, later bytes follow wr_ptr.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 6'd0;
    if (byte_strobe_s && (rx_state_q == RX_BODY)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = wr_ptr_q;
    end else if (byte_strobe_s && (rx_state_q == RX_IDLE) && !done_q) begin
      wr_en_s   = 1'b1;
      wr_addr_s = 6'd0;
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = 6'd0;
    end
  end

  // Packet storage; contents are always written before being replayed, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && (wr_addr_s < DATA_BYTES)) begin
      pkt_buf_q[wr_addr_s] <= byte_s;
    end
  end

  // Receive FSM: byte position, length latch, completion and abort detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q       <= RX_IDLE;
      wr_ptr_q         <= 6'd0;
      expected_len_q   <= 6'd0;
      done_q           <= 1'b0;
      pkt_ready_q      <= 1'b0;
      packet_dropped_q <= 1'b0;
    end else begin
      pkt_ready_q      <= 1'b0;
      packet_dropped_q <= 1'b0;
      // Re-arm only once chip select has been released.
      done_q <= cs_n_sync_s ? 1'b0 : done_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (byte_strobe_s && !done_q) begin
            expected_len_q <= pkt_len(byte_s);
            wr_ptr_q       <= 6'd1;
            rx_state_q     <= RX_BODY;
          end else begin
            rx_state_q     <= RX_IDLE;
          end
        end
        RX_BODY: begin
          if (byte_strobe_s) begin
            if ((wr_ptr_q + 6'd1) == expected_len_q) begin
              pkt_ready_q <= 1'b1;
              wr_ptr_q    <= 6'd0;
              done_q      <= 1'b1;
              rx_state_q  <= RX_IDLE;
            end else begin
              wr_ptr_q    <= wr_ptr_q + 6'd1;
            end
          end else if (cs_rise_s) begin
            packet_dropped_q <= 1'b1;
            wr_ptr_q         <= 6'd0;
            rx_state_q       <= RX_IDLE;
          end else begin
            rx_state_q       <= RX_BODY;
          end
        end
        default: begin
          wr_ptr_q   <= 6'd0;
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  // Transmit FSM: one start cycle with RX_valid, then tx_len bytes from the buffer.
  // A following packet may overwrite the buffer while streaming; its writes
  // trail the read pointer by a wide margin at sclk <= clk/4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      rd_ptr_q   <= 6'd0;
      tx_len_q   <= 6'd0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (pkt_ready_q) begin
            tx_len_q   <= expected_len_q;
            rd_ptr_q   <= 6'd0;
            rx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            tx_state_q <= TX_START;
          end else begin
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        TX_START: begin
          rx_valid_q <= 1'b0;
          data_q     <= pkt_buf_q[rd_ptr_q];
          rd_ptr_q   <= rd_ptr_q + 6'd1;
          tx_state_q <= TX_STREAM;
        end
        TX_STREAM: begin
          if (rd_ptr_q == tx_len_q) begin
            // data_q keeps the last byte until the next packet.
            busy_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else begin
            data_q     <= pkt_buf_q[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + 6'd1;
          end
        end
        default: begin
          rx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_RX_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of discarded partial packets; cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else if (packet_dropped_q && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 8'h00;
`endif

  assign bus.RX_valid        = rx_valid_q;
  assign bus.data_SPI_to_FIB = data_q;
  assign bus.busy            = busy_q;
  assign bus.packet_dropped  = packet_dropped_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
// tb_spi_rx_framer
// Drives SPI frames (directed plus $urandom packets) and compares the FIB-side
// replay with a queue-based packet model.
module tb_spi_rx_framer;
  import ndn_pkt_pkg::*;

  localparam int SCK_HALF = 40;   // 8 clk per sclk period

  logic clk = 1'b0;
  logic rst;

  spi_rx_framer_if bus ();

  spi_rx_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_bytes [$];
  int         exp_len   [$];
  int         exp_valid      = 0;
  int         n_valid        = 0;
  int         exp_drop_total = 0;
  int         exp_drop_cnt   = 0;
  int         n_drop         = 0;
  logic [7:0] tx_buf [64];

  function automatic int model_len(input logic [7:0] meta);
    return meta[6] ? 9 : 41;
  endfunction

  function automatic logic [31:0] exp_dc();
`ifdef SPI_RX_DROP_COUNT_EN
    return (exp_drop_cnt > 255) ? 32'd255 : 32'(exp_drop_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- output monitor ----------------
  int   mon_idx   = -1;
  int   mon_len   = 0;
  logic prev_drop = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_idx   = -1;
      prev_drop = 1'b0;
      exp_bytes.delete();
      exp_len.delete();
    end else begin
      if (bus.packet_dropped) begin
        n_drop++;
        check_eq("drop_pulse_one_cycle", {31'd0, prev_drop}, 32'd0);
      end
      prev_drop = bus.packet_dropped;
      if (mon_idx < 0) begin
        if (bus.RX_valid) begin
          n_valid++;
          if (exp_len.size() == 0) begin
            check_eq("unexpected_rx_valid", {31'd0, bus.RX_valid}, 32'd0);
          end else begin
            mon_len = exp_len.pop_front();
            mon_idx = 0;
            check_eq("busy_at_rx_valid", {31'd0, bus.busy}, 32'd1);
          end
        end
      end else if (mon_idx < mon_len) begin
        check_eq($sformatf("byte%0d", mon_idx), {24'd0, bus.data_SPI_to_FIB}, {24'd0, exp_bytes.pop_front()});
        check_eq("rx_valid_low_in_stream", {31'd0, bus.RX_valid}, 32'd0);
        check_eq("busy_in_stream", {31'd0, bus.busy}, 32'd1);
        mon_idx++;
      end else begin
        check_eq("busy_after_replay", {31'd0, bus.busy}, 32'd0);
        mon_idx = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = v[i];
      #(SCK_HALF);
      bus.spi_sclk = 1'b1;
      #(SCK_HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    bus.spi_cs_n = 1'b0;
    #(SCK_HALF);
  endtask

  task automatic frame_end();
    #(SCK_HALF);
    bus.spi_cs_n = 1'b1;
    #(4 * SCK_HALF);
  endtask

  task automatic expect_packet();
    int len;
    len = model_len(tx_buf[0]);
    for (int i = 0; i < len; i++) exp_bytes.push_back(tx_buf[i]);
    exp_len.push_back(len);
    exp_valid++;
  endtask

  task automatic send_packet(input int nextra);
    expect_packet();
    frame_begin();
    for (int i = 0; i < model_len(tx_buf[0]); i++) spi_byte(tx_buf[i]);
    for (int i = 0; i < nextra; i++) spi_byte(8'($urandom));
    frame_end();
  endtask

  task automatic send_abort(input int nbytes);
    frame_begin();
    for (int i = 0; i < nbytes; i++) spi_byte(tx_buf[i]);
    frame_end();
    exp_drop_total++;
    exp_drop_cnt++;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_len.size() == 0 && mon_idx < 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic fill_interest(input logic [63:0] prefix);
    tx_buf[0] = META_INTEREST;
    for (int i = 0; i < 8; i++) tx_buf[1 + i] = prefix[63 - 8 * i -: 8];
  endtask

  task automatic fill_random(input logic [7:0] meta);
    tx_buf[0] = meta;
    for (int i = 1; i < 41; i++) tx_buf[i] = 8'($urandom);
  endtask

  task automatic check_drop_count(input string tag);
    repeat (4) @(negedge clk);
    check_eq(tag, {24'd0, bus.drop_count}, exp_dc());
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(8_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    string      s;
    logic [7:0] meta;
    logic       ok;
    int         v0;

    rst          = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_valid", {31'd0, bus.RX_valid}, 32'd0);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_data", {24'd0, bus.data_SPI_to_FIB}, 32'd0);
    check_eq("reset_dropped", {31'd0, bus.packet_dropped}, 32'd0);
    check_eq("reset_drop_count", {24'd0, bus.drop_count}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Directed interest packet.
    fill_interest(64'h0000FFFF0000FFFF);
    send_packet(0);
    wait_idle("interest_replay");

    // Directed data packet: prefix + left-padded ASCII payload.
    tx_buf[0] = META_DATA;
    s = "this is an example";
    for (int i = 0; i < 14; i++) tx_buf[9 + i] = 8'h00;
    for (int i = 0; i < 18; i++) tx_buf[23 + i] = s[i];
    send_packet(0);
    wait_idle("data_replay");
    check_eq("data_last_byte_hold", {24'd0, bus.data_SPI_to_FIB}, 32'h65);

    // Abort after metadata + 3 prefix bytes, then a clean interest.
    fill_interest(64'h0123456789ABCDEF);
    send_abort(4);
    check_drop_count("drop_count_after_abort");
    check_eq("abort_no_rx_valid", 32'(n_valid), 32'(exp_valid));
    send_packet(0);
    wait_idle("post_abort_replay");

    // Chip-select toggle with only a partial byte: no effect.
    frame_begin();
    for (int i = 0; i < 3; i++) begin
      bus.spi_mosi = 1'b1;
      #(SCK_HALF); bus.spi_sclk = 1'b1; #(SCK_HALF); bus.spi_sclk = 1'b0;
    end
    frame_end();
    check_drop_count("partial_bits_no_drop");

    // Extra bytes after completion in the same frame are ignored.
    fill_interest(64'hA5A5_5A5A_1234_8765);
    send_packet(2);
    wait_idle("extra_bytes_replay");

    // Back-to-back data packets.
    v0 = n_valid;
    fill_random(META_DATA);
    send_packet(0);
    fill_random(8'h35);
    send_packet(0);
    wait_idle("back_to_back_replay");
    check_eq("back_to_back_rx_valid_count", 32'(n_valid - v0), 32'd2);

    // Reset in the middle of an interest replay.
    fill_interest(64'h0000FFFF0000FFFF);
    expect_packet();
    frame_begin();
    for (int i = 0; i < 9; i++) spi_byte(tx_buf[i]);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mon_idx == 5) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("reached_replay_byte5", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("midreset_rx_valid", {31'd0, bus.RX_valid}, 32'd0);
    check_eq("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midreset_data", {24'd0, bus.data_SPI_to_FIB}, 32'd0);
    check_eq("midreset_drop_count", {24'd0, bus.drop_count}, 32'd0);
    bus.spi_cs_n = 1'b1;
    exp_drop_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    fill_interest(64'hDEAD_BEEF_CAFE_F00D);
    send_packet(0);
    wait_idle("post_reset_replay");

    // Randomised packets and aborts.
    for (int p = 0; p < 10; p++) begin
      meta = 8'($urandom);
      fill_random(meta);
      if ($urandom_range(0, 3) == 0) begin
        send_abort($urandom_range(1, model_len(meta) - 1));
        check_drop_count("rand_drop_count");
      end else begin
        send_packet($urandom_range(0, 1));
        wait_idle("rand_replay");
      end
    end

    // Saturation of the drop counter.
    tx_buf[0] = META_DATA;
    for (int i = 0; i < 260; i++) send_abort(1);
    check_drop_count("drop_count_saturation");

    repeat (10) @(negedge clk);
    check_eq("rx_valid_total", 32'(n_valid), 32'(exp_valid));
    check_eq("drop_pulse_total", 32'(n_drop), 32'(exp_drop_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rx_framer.md
Name: spi_rx_framer

Overview:
- Sits between the SPI slave pins and fib_table's SPI input (RX_valid / data_SPI_to_FIB).
- Deserialises MOSI bits into bytes and buffers one complete NDN packet.
- Byte 0 of each packet is metadata; it sets the packet length: interest is 9 bytes (metadata + 64-bit prefix); data is 41 bytes (metadata + prefix + 256-bit payload).
- Once a packet is complete, replays it to the FIB: one RX_valid pulse, then one byte per clock.

Parameters:
- INTEREST_BYTES, 9: total interest packet length in bytes.
- DATA_BYTES, 41: total data packet length in bytes; also the buffer depth.
- TYPE_BIT, 6: metadata bit index. 1 = interest, 0 = data (0x70 is interest, 0x30 is data).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- spi_sclk  in  1  SPI clock, asynchronous to clk; must be ≤ clk/4.
- spi_mosi  in  1  SPI data, MSB first, sampled on sclk rising edge (mode 0).
- spi_cs_n  in  1  SPI chip select, active-low, frames one packet.
- RX_valid  out  1  one-cycle packet-start pulse to the FIB.
- data_SPI_to_FIB  out  8  packet byte to the FIB.
- busy  out  1  high while a packet is being replayed.
- packet_dropped  out  1  one-cycle pulse when a partial packet is discarded.
- drop_count  out  8  saturating count of dropped packets (see Optional Feature).

Behaviour:
- Reset: all outputs are 0; state is IDLE; buffer pointers are 0; shift register and bit counter are cleared; synchroniser flops are set to sclk=0, mosi=0, cs_n=1.
- Synchronisation: spi_sclk, spi_mosi and spi_cs_n each pass through 2-FF synchronisers. The sclk rising edge is detected from the synchronised sclk vs its previous value.
- Deserialiser: while cs_n is low, each sclk rise shifts mosi in. The 8th bit produces a byte strobe, writes the byte to buffer[wr_ptr] and increments wr_ptr. cs_n rising resets the bit counter.
- Length latch: when byte 0 is written, expected_len = metadata[TYPE_BIT] ? INTEREST_BYTES : DATA_BYTES.
- Receive FSM, states RX_IDLE, RX_BODY:
  - RX_IDLE → RX_BODY on the first byte strobe.
  - In RX_BODY, when wr_ptr reaches expected_len: raise pkt_ready, reset wr_ptr to 0, return to RX_IDLE.
  - cs_n rising while in RX_BODY with wr_ptr < expected_len: discard the packet, pulse packet_dropped, wr_ptr = 0, return to RX_IDLE.
  - Bytes clocked after the packet is complete but before cs_n rises are ignored and do not start a new packet. Re-arming requires cs_n to rise and then fall.
  - cs_n toggling with no complete byte has no effect.
- Transmit FSM, states TX_IDLE, TX_START, TX_STREAM:
  - TX_IDLE → TX_START on pkt_ready; latch tx_len = expected_len.
  - TX_START lasts one cycle with RX_valid = 1 and busy = 1.
  - TX_STREAM: cycles 1..tx_len after the pulse, data_SPI_to_FIB = buffer[k] for k = 0..tx_len-1, with RX_valid = 0.
  - After the last byte, go to TX_IDLE with busy = 0. data_SPI_to_FIB holds the last byte until the next packet.
- Latency: RX_valid rises 2 clk after the synchronised final-byte strobe (pkt_ready registered, then TX_START).
- Overlap: a new packet may be received while TX_STREAM is running. The write for byte k occurs ≥32(k+1) clocks after replay start, so the read pointer always leads and no arbitration is needed.
- pkt_ready while busy cannot occur given the sclk ≤ clk/4 rule. The block does not handle it.
- Reset asserted mid-operation: both FSMs return to idle immediately, RX_valid = 0, and the partial packet is lost without a packet_dropped pulse.

Optional Feature:
- Macro SPI_RX_DROP_COUNT_EN.
- Defined: drop_count increments on each packet_dropped pulse, saturates at 255, and clears only on reset.
- Undefined: drop_count is tied to 0 and no counter flops exist. packet_dropped behaves identically in both cases.

Decomposition:
- Package ndn_pkt_pkg holds:
  - constants INTEREST_BYTES, DATA_BYTES, TYPE_BIT;
  - the metadata type encodings (8'h70 interest, 8'h30 data);
  - rx/tx state enums.
- Sub-module spi_byte_deserializer holds the 2-FF synchronisers, sclk edge detect and shift/bit counter. It outputs byte[7:0], byte_strobe, cs_rise and cs_n_sync.

Test Plan:
- Interest: cs_n low, send 0x70 then 0x0000FFFF0000FFFF, cs_n high. Expect one RX_valid pulse, then 9 consecutive bytes 70 00 00 FF FF 00 00 FF FF, and busy high for 10 cycles.
- Data: send 0x30, prefix 0x0000FFFF0000FFFF, then the 32-byte ASCII "this is an example" left-padded with 0x00 to 32 bytes. Expect RX_valid, then 41 bytes in order, the last being 0x65 ('e').
- Abort: send 0x70 plus 3 prefix bytes, then cs_n high. Expect packet_dropped for one cycle, no RX_valid, and drop_count = 1 with the macro (0 without). The following interest packet is replayed correctly.
- Back-to-back: a second 41-byte data packet starts immediately after the first completes. Both replays are byte-exact and RX_valid pulses exactly twice.
- Reset mid-replay: assert rst low at byte 5 of an interest replay. Outputs go to 0 asynchronously, and after release the next packet replays correctly.
- Saturation (macro on): 260 aborted packets → drop_count = 255.
